// File: rtl/axi_chk_pkg.sv
// Shared types for the AXI protocol checker: error bit indices, burst encodings,
// and the burst-legality / priority helpers used by the top level.
package axi_chk_pkg;

    localparam int ERR_W = 11;

    typedef enum int unsigned {
        ERR_AW_STABLE     = 0,
        ERR_W_STABLE      = 1,
        ERR_AR_STABLE     = 2,
        ERR_WLAST         = 3,
        ERR_RLAST         = 4,
        ERR_B_UNEXP       = 5,
        ERR_R_UNEXP       = 6,
        ERR_W_UNEXP       = 7,
        ERR_OVERFLOW      = 8,
        ERR_TIMEOUT       = 9,
        ERR_BURST_ILLEGAL = 10
    } err_idx_e;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    // INCR span is measured from the size-aligned start, so an unaligned first beat
    // is judged by the address window the whole burst occupies.
    function automatic logic burst_legal(input logic [11:0] addr_lo, input logic [7:0] len,
                                         input logic [2:0] size, input burst_e burst,
                                         input logic [2:0] max_size);
        logic        ok;
        logic [16:0] start;
        logic [16:0] span;
        ok    = 1'b1;
        start = '0;
        span  = '0;
        if (size > max_size) ok = 1'b0;
        case (burst)
            BURST_FIXED: ;
            BURST_INCR: begin
                start = {5'd0, (addr_lo >> size) << size};
                span  = ({9'd0, len} + 17'd1) << size;
                if (start + span > 17'h01000) ok = 1'b0;
            end
            BURST_WRAP: begin
                if (!(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) ok = 1'b0;
            end
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] lowest_set(input logic [ERR_W-1:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = ERR_W - 1; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/axi_chk_len_fifo.sv
// Synchronous FIFO of burst lengths (awlen/arlen) with occupancy count.
// A push while full is accepted only if a pop frees the head in the same cycle.
module axi_chk_len_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_push,
    input  logic                    i_pop,
    input  logic [7:0]              i_data,
    output logic [7:0]              o_head,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == (PTR_W + 1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/axi_protocol_checker.sv
// Passive AXI4 protocol checker: tracks outstanding bursts, beat counts, handshake
// stability and stalls on one port and reports violations as sticky bits plus a pulse.
module axi_protocol_checker
    import axi_chk_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 8,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                              i_axi_aclk,
    input  logic                              i_axi_reset,
    input  logic                              i_awvalid,
    input  logic                              i_awready,
    input  logic [ADDR_WIDTH-1:0]             i_awaddr,
    input  logic [7:0]                        i_awlen,
    input  logic [2:0]                        i_awsize,
    input  logic [1:0]                        i_awburst,
    input  logic                              i_wvalid,
    input  logic                              i_wready,
    input  logic [DATA_WIDTH-1:0]             i_wdata,
    input  logic [DATA_WIDTH/8-1:0]           i_wstrb,
    input  logic                              i_wlast,
    input  logic                              i_bvalid,
    input  logic                              i_bready,
    input  logic                              i_arvalid,
    input  logic                              i_arready,
    input  logic [ADDR_WIDTH-1:0]             i_araddr,
    input  logic [7:0]                        i_arlen,
    input  logic [2:0]                        i_arsize,
    input  logic [1:0]                        i_arburst,
    input  logic                              i_rvalid,
    input  logic                              i_rready,
    input  logic                              i_rlast,
    input  logic                              i_err_clear,
    output logic [ERR_W-1:0]                  o_err_sticky,
    output logic [ERR_W-1:0]                  o_err_pulse,
    output logic                              o_err_any,
    output logic [3:0]                        o_first_err_code,
    output logic [$clog2(MAX_OUTSTANDING):0]  o_wr_outstanding,
    output logic [$clog2(MAX_OUTSTANDING):0]  o_rd_outstanding
);
    localparam int             AX_PW    = ADDR_WIDTH + 13;
    localparam int             W_PW     = DATA_WIDTH + DATA_WIDTH / 8 + 1;
    localparam logic [2:0]     MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));
    localparam int             TO_W     = $clog2(TIMEOUT_CYCLES + 2);
    localparam bit             TO_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [TO_W-1:0] TO_SAT  = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    assign w_aw_hs = i_awvalid && i_awready;
    assign w_w_hs  = i_wvalid && i_wready;
    assign w_b_hs  = i_bvalid && i_bready;
    assign w_ar_hs = i_arvalid && i_arready;
    assign w_r_hs  = i_rvalid && i_rready;

    logic [AX_PW-1:0] w_aw_payload, r_aw_payload, w_ar_payload, r_ar_payload;
    logic [W_PW-1:0]  w_w_payload, r_w_payload;
    logic             r_aw_stall, r_w_stall, r_ar_stall;
    assign w_aw_payload = {i_awaddr, i_awlen, i_awsize, i_awburst};
    assign w_ar_payload = {i_araddr, i_arlen, i_arsize, i_arburst};
    assign w_w_payload  = {i_wdata, i_wstrb, i_wlast};

    logic [7:0]                        w_aw_head, w_ar_head;
    logic                              w_aw_full, w_aw_empty, w_ar_full, w_ar_empty;
    logic                              w_aw_pop, w_ar_pop;
    logic                              w_w_last_exp, w_r_last_exp;
    logic [7:0]                        r_w_beat, r_r_beat, r_b_pending;
    logic                              w_b_dec;

    assign w_w_last_exp = (r_w_beat == w_aw_head);
    assign w_r_last_exp = (r_r_beat == w_ar_head);
    assign w_aw_pop     = w_w_hs && !w_aw_empty && w_w_last_exp;
    assign w_ar_pop     = w_r_hs && !w_ar_empty && w_r_last_exp;
    assign w_b_dec      = w_b_hs && (r_b_pending != '0);

    axi_chk_len_fifo #(.DEPTH(MAX_OUTSTANDING)) u_aw_fifo (
        .i_clk   (i_axi_aclk),
        .i_reset (i_axi_reset),
        .i_push  (w_aw_hs),
        .i_pop   (w_aw_pop),
        .i_data  (i_awlen),
        .o_head  (w_aw_head),
        .o_full  (w_aw_full),
        .o_empty (w_aw_empty),
        .o_count (o_wr_outstanding)
    );

    axi_chk_len_fifo #(.DEPTH(MAX_OUTSTANDING)) u_ar_fifo (
        .i_clk   (i_axi_aclk),
        .i_reset (i_axi_reset),
        .i_push  (w_ar_hs),
        .i_pop   (w_ar_pop),
        .i_data  (i_arlen),
        .o_head  (w_ar_head),
        .o_full  (w_ar_full),
        .o_empty (w_ar_empty),
        .o_count (o_rd_outstanding)
    );

    // Channel order for stall tracking: AW, W, B, AR, R
    logic [4:0]      w_stall, w_to_hit;
    logic [TO_W-1:0] r_to_cnt [5];
    assign w_stall = {i_rvalid && !i_rready, i_arvalid && !i_arready, i_bvalid && !i_bready,
                      i_wvalid && !i_wready, i_awvalid && !i_awready};

    always_comb begin
        w_to_hit = '0;
        for (int i = 0; i < 5; i++) begin
            w_to_hit[i] = TO_EN && w_stall[i] && (r_to_cnt[i] == TO_LAST);
        end
    end

    logic [ERR_W-1:0] w_err;
    always_comb begin
        w_err = '0;
        w_err[ERR_AW_STABLE] = r_aw_stall && (!i_awvalid || (w_aw_payload != r_aw_payload));
        w_err[ERR_W_STABLE]  = r_w_stall && (!i_wvalid || (w_w_payload != r_w_payload));
        w_err[ERR_AR_STABLE] = r_ar_stall && (!i_arvalid || (w_ar_payload != r_ar_payload));
        w_err[ERR_WLAST]     = w_w_hs && !w_aw_empty && (i_wlast != w_w_last_exp);
        w_err[ERR_RLAST]     = w_r_hs && !w_ar_empty && (i_rlast != w_r_last_exp);
        w_err[ERR_B_UNEXP]   = w_b_hs && (r_b_pending == '0);
        w_err[ERR_R_UNEXP]   = w_r_hs && w_ar_empty;
        w_err[ERR_W_UNEXP]   = w_w_hs && w_aw_empty;
        w_err[ERR_OVERFLOW]  = (w_aw_hs && w_aw_full && !w_aw_pop) ||
                               (w_ar_hs && w_ar_full && !w_ar_pop);
        w_err[ERR_TIMEOUT]   = |w_to_hit;
        w_err[ERR_BURST_ILLEGAL] =
            (w_aw_hs && !burst_legal(i_awaddr[11:0], i_awlen, i_awsize, burst_e'(i_awburst), MAX_SIZE)) ||
            (w_ar_hs && !burst_legal(i_araddr[11:0], i_arlen, i_arsize, burst_e'(i_arburst), MAX_SIZE));
    end

    always_ff @(posedge i_axi_aclk) begin
        if (i_axi_reset) begin
            r_aw_stall   <= 1'b0;
            r_w_stall    <= 1'b0;
            r_ar_stall   <= 1'b0;
            r_aw_payload <= '0;
            r_w_payload  <= '0;
            r_ar_payload <= '0;
        end else begin
            r_aw_stall   <= w_stall[0];
            r_w_stall    <= w_stall[1];
            r_ar_stall   <= w_stall[3];
            r_aw_payload <= w_aw_payload;
            r_w_payload  <= w_w_payload;
            r_ar_payload <= w_ar_payload;
        end
    end

    always_ff @(posedge i_axi_aclk) begin
        if (i_axi_reset) begin
            r_w_beat    <= '0;
            r_r_beat    <= '0;
            r_b_pending <= '0;
        end else begin
            if (w_w_hs && !w_aw_empty) r_w_beat <= w_w_last_exp ? 8'd0 : r_w_beat + 8'd1;
            if (w_r_hs && !w_ar_empty) r_r_beat <= w_r_last_exp ? 8'd0 : r_r_beat + 8'd1;
            case ({w_aw_pop, w_b_dec})
                2'b10:   if (r_b_pending != 8'hFF) r_b_pending <= r_b_pending + 8'd1;
                2'b01:   r_b_pending <= r_b_pending - 8'd1;
                default: r_b_pending <= r_b_pending;
            endcase
        end
    end

    // Counters saturate at TIMEOUT_CYCLES so a long stall reports exactly once.
    always_ff @(posedge i_axi_aclk) begin
        for (int i = 0; i < 5; i++) begin
            if (i_axi_reset || !w_stall[i]) r_to_cnt[i] <= '0;
            else if (r_to_cnt[i] != TO_SAT) r_to_cnt[i] <= r_to_cnt[i] + 1'b1;
        end
    end

    logic r_first_valid;
    always_ff @(posedge i_axi_aclk) begin
        if (i_axi_reset) begin
            o_err_pulse      <= '0;
            o_err_sticky     <= '0;
            o_first_err_code <= '0;
            r_first_valid    <= 1'b0;
        end else begin
            o_err_pulse <= w_err;
            if (i_err_clear) begin
                o_err_sticky     <= '0;
                o_first_err_code <= '0;
                r_first_valid    <= 1'b0;
            end else begin
                o_err_sticky <= o_err_sticky | w_err;
                if (!r_first_valid && (w_err != '0)) begin
                    o_first_err_code <= lowest_set(w_err);
                    r_first_valid    <= 1'b1;
                end
            end
        end
    end

    assign o_err_any = |o_err_sticky;

endmodule

// File: tb/tb_axi_protocol_checker.sv
// Directed self-checking bench: one checker with a 16-cycle timeout and a twin with timeout disabled.
module tb_axi_protocol_checker;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [AW-1:0] awaddr, araddr;
    logic [7:0]    awlen, arlen;
    logic [2:0]    awsize, arsize;
    logic [1:0]    awburst, arburst;
    logic [DW-1:0] wdata;
    logic [DW/8-1:0] wstrb;
    logic          wlast, rlast, err_clear;

    logic [10:0] sticky, pulse, sticky_nt, pulse_nt;
    logic        any, any_nt;
    logic [3:0]  first, first_nt;
    logic [3:0]  wr_out, rd_out, wr_out_nt, rd_out_nt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    axi_protocol_checker #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(8), .TIMEOUT_CYCLES(16)) dut (
        .i_axi_aclk(clk), .i_axi_reset(rst),
        .i_awvalid(awvalid), .i_awready(awready), .i_awaddr(awaddr), .i_awlen(awlen),
        .i_awsize(awsize), .i_awburst(awburst),
        .i_wvalid(wvalid), .i_wready(wready), .i_wdata(wdata), .i_wstrb(wstrb), .i_wlast(wlast),
        .i_bvalid(bvalid), .i_bready(bready),
        .i_arvalid(arvalid), .i_arready(arready), .i_araddr(araddr), .i_arlen(arlen),
        .i_arsize(arsize), .i_arburst(arburst),
        .i_rvalid(rvalid), .i_rready(rready), .i_rlast(rlast),
        .i_err_clear(err_clear),
        .o_err_sticky(sticky), .o_err_pulse(pulse), .o_err_any(any), .o_first_err_code(first),
        .o_wr_outstanding(wr_out), .o_rd_outstanding(rd_out)
    );

    axi_protocol_checker #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(8), .TIMEOUT_CYCLES(0)) dut_nt (
        .i_axi_aclk(clk), .i_axi_reset(rst),
        .i_awvalid(awvalid), .i_awready(awready), .i_awaddr(awaddr), .i_awlen(awlen),
        .i_awsize(awsize), .i_awburst(awburst),
        .i_wvalid(wvalid), .i_wready(wready), .i_wdata(wdata), .i_wstrb(wstrb), .i_wlast(wlast),
        .i_bvalid(bvalid), .i_bready(bready),
        .i_arvalid(arvalid), .i_arready(arready), .i_araddr(araddr), .i_arlen(arlen),
        .i_arsize(arsize), .i_arburst(arburst),
        .i_rvalid(rvalid), .i_rready(rready), .i_rlast(rlast),
        .i_err_clear(err_clear),
        .o_err_sticky(sticky_nt), .o_err_pulse(pulse_nt), .o_err_any(any_nt), .o_first_err_code(first_nt),
        .o_wr_outstanding(wr_out_nt), .o_rd_outstanding(rd_out_nt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        awvalid = 0; awready = 0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01;
        wvalid = 0; wready = 0; wdata = '0; wstrb = '0; wlast = 0;
        bvalid = 0; bready = 0;
        arvalid = 0; arready = 0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01;
        rvalid = 0; rready = 0; rlast = 0;
        err_clear = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic aw_send(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] b);
        awvalid = 1; awready = 1; awaddr = a; awlen = l; awsize = s; awburst = b;
        step();
        awvalid = 0; awready = 0;
    endtask

    task automatic ar_send(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] b);
        arvalid = 1; arready = 1; araddr = a; arlen = l; arsize = s; arburst = b;
        step();
        arvalid = 0; arready = 0;
    endtask

    task automatic w_beat(input logic last, input logic [31:0] d);
        wvalid = 1; wready = 1; wlast = last; wdata = d; wstrb = 4'hF;
        step();
        wvalid = 0; wready = 0; wlast = 0;
    endtask

    task automatic r_beat(input logic last);
        rvalid = 1; rready = 1; rlast = last;
        step();
        rvalid = 0; rready = 0; rlast = 0;
    endtask

    task automatic b_resp();
        bvalid = 1; bready = 1;
        step();
        bvalid = 0; bready = 0;
    endtask

    initial begin
        int n_to, n_to_nt, first_to;

        // Reset state
        do_reset();
        chk("rst_sticky", 32'(sticky), 32'h0);
        chk("rst_pulse", 32'(pulse), 32'h0);
        chk("rst_any", 32'(any), 32'h0);
        chk("rst_first", 32'(first), 32'h0);
        chk("rst_wr_out", 32'(wr_out), 32'h0);
        chk("rst_rd_out", 32'(rd_out), 32'h0);

        // Legal INCR write, len=3
        aw_send(32'h100, 8'd3, 3'd2, 2'b01);
        chk("wr_aw_queued", 32'(wr_out), 32'd1);
        for (int i = 0; i < 4; i++) w_beat(i == 3, 32'hA000 + 32'(i));
        chk("wr_drained", 32'(wr_out), 32'd0);
        b_resp();
        chk("wr_sticky", 32'(sticky), 32'h0);
        chk("wr_pulse", 32'(pulse), 32'h0);

        // AW payload change while stalled
        do_reset();
        awvalid = 1; awready = 0; awaddr = 32'h1000; awlen = 0; awsize = 3'd2; awburst = 2'b01;
        step();
        chk("aw_stall_no_err", 32'(pulse), 32'h0);
        awaddr = 32'h1004;
        step();
        chk("aw_stable_pulse", 32'(pulse), 32'h001);
        chk("aw_stable_first", 32'(first), 32'd0);
        chk("aw_stable_any", 32'(any), 32'd1);
        awready = 1;
        step();
        chk("aw_pulse_one_cycle", 32'(pulse), 32'h0);
        chk("aw_sticky_held", 32'(sticky), 32'h001);
        idle();

        // AR len=7 with rlast on beat 6, then stray R
        do_reset();
        ar_send(32'h200, 8'd7, 3'd2, 2'b01);
        for (int i = 0; i < 8; i++) begin
            r_beat(i == 5);
            if (i == 5) chk("rlast_early", 32'(pulse), 32'h010);
            if (i == 7) chk("rlast_missing", 32'(pulse), 32'h010);
        end
        chk("rd_drained", 32'(rd_out), 32'd0);
        r_beat(1'b1);
        chk("r_unexp_pulse", 32'(pulse), 32'h040);
        chk("r_sticky", 32'(sticky), 32'h050);
        chk("r_first", 32'(first), 32'd4);

        // Overflow at 9th AW, then clear racing a same-cycle violation
        do_reset();
        awvalid = 1; awready = 1; awaddr = 32'h0; awlen = 0; awsize = 3'd2; awburst = 2'b01;
        for (int i = 0; i < 8; i++) step();
        chk("ovf_full_count", 32'(wr_out), 32'd8);
        chk("ovf_none_yet", 32'(sticky), 32'h0);
        step();
        chk("ovf_pulse", 32'(pulse), 32'h100);
        chk("ovf_count_sat", 32'(wr_out), 32'd8);
        chk("ovf_first", 32'(first), 32'd8);
        err_clear = 1;
        step();
        chk("clr_wins_sticky", 32'(sticky), 32'h0);
        chk("clr_pulse_still", 32'(pulse), 32'h100);
        chk("clr_first", 32'(first), 32'd0);
        idle();
        step();
        chk("clr_any", 32'(any), 32'd0);

        // Burst legality on AR
        do_reset();
        ar_send(32'h0, 8'd0, 3'd2, 2'b11);
        chk("burst_rsvd", 32'(pulse), 32'h400);
        ar_send(32'hFF0, 8'd7, 3'd2, 2'b01);
        chk("incr_cross_4k", 32'(pulse), 32'h400);
        ar_send(32'hFE0, 8'd7, 3'd2, 2'b01);
        chk("incr_to_4k_edge", 32'(pulse), 32'h0);
        ar_send(32'h40, 8'd2, 3'd2, 2'b10);
        chk("wrap_len_bad", 32'(pulse), 32'h400);
        ar_send(32'h40, 8'd3, 3'd2, 2'b10);
        chk("wrap_len_ok", 32'(pulse), 32'h0);
        ar_send(32'h40, 8'd0, 3'd3, 2'b01);
        chk("size_too_big", 32'(pulse), 32'h400);

        // AR stall timeout: 16 -> one pulse after the 16th stall cycle; 0 -> none
        do_reset();
        arvalid = 1; arready = 0; araddr = 32'h80; arlen = 0; arsize = 3'd2; arburst = 2'b01;
        n_to = 0; n_to_nt = 0; first_to = 0;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (pulse[9]) begin
                n_to++;
                if (first_to == 0) first_to = i;
            end
            if (pulse_nt[9]) n_to_nt++;
        end
        chk("to_pulse_count", 32'(n_to), 32'd1);
        chk("to_pulse_cycle", 32'(first_to), 32'd16);
        chk("to_disabled", 32'(n_to_nt), 32'd0);
        chk("to_sticky", 32'(sticky), 32'h200);
        arready = 1;
        step();
        idle();

        // Reset mid write burst, then a clean burst
        do_reset();
        aw_send(32'h300, 8'd3, 3'd2, 2'b01);
        w_beat(1'b0, 32'h1);
        w_beat(1'b0, 32'h2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_wr_out", 32'(wr_out), 32'd0);
        chk("mid_rst_sticky", 32'(sticky), 32'h0);
        chk("mid_rst_pulse", 32'(pulse), 32'h0);
        aw_send(32'h400, 8'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++) w_beat(i == 3, 32'hB0 + 32'(i));
        b_resp();
        chk("post_rst_sticky", 32'(sticky), 32'h0);
        chk("post_rst_wr_out", 32'(wr_out), 32'd0);

        // Unexpected B and W
        b_resp();
        chk("b_unexp", 32'(pulse), 32'h020);
        w_beat(1'b1, 32'h5);
        chk("w_unexp", 32'(pulse), 32'h080);
        chk("unexp_first", 32'(first), 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
